// File: rtl/line_rasterizer.sv
// line_rasterizer
// ---------------
// Bresenham line engine that feeds the framebuffer write port. One accepted
// line command (two endpoints plus colour) becomes a stream of one pixel per
// clock. Coordinates are framebuffer-local; pixels outside WIDTH x HEIGHT
// still take their cycle but are issued with we=0.
//
// Handshake: start is only looked at while idle (busy=0). A start seen at a
// rising edge in IDLE latches x0/y0/x1/y1/color; busy rises the next cycle and
// stays high through the one-cycle done pulse. Starts while busy are dropped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             line command request (IDLE only)
//   x0, y0, x1, y1    endpoints, unsigned, XY_BITW bits
//   color             line colour
//   busy              high from the cycle after accept through the DONE cycle
//   done              one-cycle pulse after the last pixel
//   we, x, y          framebuffer write strobe and pixel address
//   pixel_color       framebuffer write data
//
// The FSM state is held in the enum signal `state` for probing.
module line_rasterizer #(
  parameter int XY_BITW = 16,
  parameter int WIDTH   = 100,
  parameter int HEIGHT  = 100,
  parameter int COLORW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [XY_BITW-1:0] x0,
  input  logic [XY_BITW-1:0] y0,
  input  logic [XY_BITW-1:0] x1,
  input  logic [XY_BITW-1:0] y1,
  input  logic [COLORW-1:0]  color,
  output logic               busy,
  output logic               done,
  output logic               we,
  output logic [XY_BITW-1:0] x,
  output logic [XY_BITW-1:0] y,
  output logic [COLORW-1:0]  pixel_color
);

  // Error term width: |delta| needs XY_BITW+1 bits plus sign; doubling needs one more.
  localparam int SW = XY_BITW + 2;
  localparam int EW = XY_BITW + 3;

  localparam logic [XY_BITW:0]   W_LIM = WIDTH[XY_BITW:0];
  localparam logic [XY_BITW:0]   H_LIM = HEIGHT[XY_BITW:0];
  localparam logic [XY_BITW-1:0] ONE   = {{(XY_BITW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched command
  logic [XY_BITW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [XY_BITW-1:0] x0_nxt, y0_nxt, x1_nxt, y1_nxt;
  logic [COLORW-1:0]  color_q, color_nxt;

  // Bresenham working set
  logic signed [SW-1:0] dx_q, dy_q, err_q;
  logic signed [SW-1:0] dx_nxt, dy_nxt, err_nxt;
  logic                 sx_pos_q, sy_pos_q, sx_pos_nxt, sy_pos_nxt;

  // Registered outputs
  logic               busy_nxt, done_nxt, we_nxt;
  logic [XY_BITW-1:0] x_nxt, y_nxt;
  logic [COLORW-1:0]  pc_nxt;

  // Deltas from the latched endpoints (zero-extended so the subtraction is signed-safe)
  logic signed [SW-1:0] diff_x, diff_y, abs_x, abs_y;
  assign diff_x = $signed({2'b00, x1_q}) - $signed({2'b00, x0_q});
  assign diff_y = $signed({2'b00, y1_q}) - $signed({2'b00, y0_q});
  assign abs_x  = diff_x[SW-1] ? -diff_x : diff_x;
  assign abs_y  = diff_y[SW-1] ? -diff_y : diff_y;

  // Step decisions; both compare against the pre-update error.
  logic signed [EW-1:0] e2, dx_e, dy_e;
  logic                 step_x, step_y, at_end;
  logic [XY_BITW-1:0]   x_step, y_step;
  assign e2     = $signed({err_q, 1'b0});
  assign dx_e   = $signed({dx_q[SW-1], dx_q});
  assign dy_e   = $signed({dy_q[SW-1], dy_q});
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);
  assign x_step = step_x ? (sx_pos_q ? x + ONE : x - ONE) : x;
  assign y_step = step_y ? (sy_pos_q ? y + ONE : y - ONE) : y;
  assign at_end = (x == x1_q) && (y == y1_q);

  function automatic logic in_fb(input logic [XY_BITW-1:0] px, input logic [XY_BITW-1:0] py);
    return ({1'b0, px} < W_LIM) && ({1'b0, py} < H_LIM);
  endfunction

  always_comb begin
    state_nxt  = state;
    x0_nxt     = x0_q;
    y0_nxt     = y0_q;
    x1_nxt     = x1_q;
    y1_nxt     = y1_q;
    color_nxt  = color_q;
    dx_nxt     = dx_q;
    dy_nxt     = dy_q;
    err_nxt    = err_q;
    sx_pos_nxt = sx_pos_q;
    sy_pos_nxt = sy_pos_q;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    we_nxt     = 1'b0;
    x_nxt      = x;
    y_nxt      = y;
    pc_nxt     = pixel_color;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          x0_nxt    = x0;
          y0_nxt    = y0;
          x1_nxt    = x1;
          y1_nxt    = y1;
          color_nxt = color;
          busy_nxt  = 1'b1;
          state_nxt = INIT;
        end
      end
      INIT: begin
        dx_nxt     = abs_x;
        dy_nxt     = -abs_y;
        err_nxt    = abs_x - abs_y;
        sx_pos_nxt = (x0_q < x1_q);
        sy_pos_nxt = (y0_q < y1_q);
        // The first pixel is loaded here so it is on the outputs in the first DRAW cycle.
        x_nxt      = x0_q;
        y_nxt      = y0_q;
        pc_nxt     = color_q;
        we_nxt     = in_fb(x0_q, y0_q);
        state_nxt  = DRAW;
      end
      DRAW: begin
        if (at_end) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          x_nxt   = x_step;
          y_nxt   = y_step;
          err_nxt = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
          we_nxt  = in_fb(x_step, y_step);
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_pos_q    <= 1'b0;
      sy_pos_q    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      we          <= 1'b0;
      x           <= '0;
      y           <= '0;
      pixel_color <= '0;
    end else begin
      state       <= state_nxt;
      x0_q        <= x0_nxt;
      y0_q        <= y0_nxt;
      x1_q        <= x1_nxt;
      y1_q        <= y1_nxt;
      color_q     <= color_nxt;
      dx_q        <= dx_nxt;
      dy_q        <= dy_nxt;
      err_q       <= err_nxt;
      sx_pos_q    <= sx_pos_nxt;
      sy_pos_q    <= sy_pos_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      we          <= we_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      pixel_color <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Testbench for line_rasterizer: directed lines from the test plan plus
// random lines checked against a Bresenham reference model.
module tb_line_rasterizer;

  localparam int XYW = 16;
  localparam int FBW = 100;
  localparam int FBH = 100;
  localparam int CW  = 3;
  localparam int PW  = 1 + XYW + XYW + CW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [XYW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [CW-1:0]  color = '0;
  logic           busy, done, we;
  logic [XYW-1:0] x, y;
  logic [CW-1:0]  pixel_color;

  int n_checks = 0;
  int n_pass   = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] obs_q[$];
  bit            timed_out;
  logic          busy_at_done;

  line_rasterizer #(.XY_BITW(XYW), .WIDTH(FBW), .HEIGHT(FBH), .COLORW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
    .busy(busy), .done(done), .we(we), .x(x), .y(y), .pixel_color(pixel_color)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Walks the line with the textbook integer Bresenham rules and records every
  // emitted pixel as {we, x, y, color}.
  function automatic void build_exp(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
    int px, py, dx, dy, sx, sy, err, e2;
    logic w;
    exp_q.delete();
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    px  = ax0;
    py  = ay0;
    for (int k = 0; k < 100000; k++) begin
      w = (px < FBW) && (py < FBH);
      exp_q.push_back({w, 16'(px), 16'(py), 3'(c)});
      if (px == ax1 && py == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; px += sx; end
      if (e2 <= dx) begin err += dx; py += sy; end
    end
  endfunction

  function automatic logic [PW-1:0] pix(input int px, input int py, input int c);
    logic w;
    w = (px < FBW) && (py < FBH);
    return {w, 16'(px), 16'(py), 3'(c)};
  endfunction

  // ---------------- driver tasks ----------------
  // Returns at the falling edge inside the INIT cycle.
  task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
    @(negedge clk);
    x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1); color = 3'(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records every DRAW-cycle output until done is seen (bounded).
  task automatic capture();
    obs_q.delete();
    timed_out    = 1'b1;
    busy_at_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        timed_out    = 1'b0;
        busy_at_done = busy;
        break;
      end
      obs_q.push_back({we, x, y, pixel_color});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, we, x, y, pixel_color} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b x=%0d y=%0d c=%0d required all zero",
               busy, done, we, x, y, pixel_color);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, we} !== 3'b000)
      $display("FAIL idle_after_reset: got busy=%b done=%b we=%b required 000", busy, done, we);
    else n_pass++;
  endtask

  task automatic test_horizontal();
    exp_q.delete();
    for (int i = 0; i <= 4; i++) exp_q.push_back({1'b1, 16'(i), 16'd0, 3'b101});
    start_line(0, 0, 4, 0, 5);
    n_checks++;
    if ({busy, we} !== 2'b10)
      $display("FAIL horiz_init_cycle: got busy=%b we=%b required busy=1 we=0", busy, we);
    else n_pass++;
    capture();
    n_checks++;
    if (timed_out || busy_at_done !== 1'b1)
      $display("FAIL horiz_done: got timeout=%0d busy_at_done=%b required 0/1", timed_out, busy_at_done);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL horiz_count: got %0d required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL horiz_pix[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done, we} !== 3'b000)
      $display("FAIL horiz_after_done: got busy=%b done=%b we=%b required 000", busy, done, we);
    else n_pass++;
  endtask

  task automatic test_fixed_path(input string name, input int ax0, input int ay0, input int ax1,
                                 input int ay1, input int c);
    // Expected sequences come from the test plan's literal pixel lists.
    exp_q.delete();
    if (name == "steep") begin
      exp_q.push_back(pix(0, 0, c)); exp_q.push_back(pix(0, 1, c)); exp_q.push_back(pix(1, 2, c));
      exp_q.push_back(pix(1, 3, c)); exp_q.push_back(pix(2, 4, c)); exp_q.push_back(pix(2, 5, c));
    end else if (name == "reversed") begin
      exp_q.push_back(pix(10, 10, c)); exp_q.push_back(pix(9, 11, c));
      exp_q.push_back(pix(8, 12, c));  exp_q.push_back(pix(7, 13, c));
    end else if (name == "single") begin
      exp_q.push_back(pix(3, 3, c));
    end else begin
      for (int i = 98; i <= 102; i++) exp_q.push_back(pix(i, 50, c));
    end
    start_line(ax0, ay0, ax1, ay1, c);
    capture();
    n_checks++;
    if (timed_out)
      $display("FAIL %s_timeout: no done within budget", name);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL %s_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL %s_pix[%0d]: got %h required %h", name, i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int busy_seen;
    build_exp(0, 0, 7, 3, 2);
    start_line(0, 0, 7, 3, 2);
    fork
      capture();
      begin
        repeat (3) @(negedge clk);
        x0 = 16'd50; y0 = 16'd60; x1 = 16'd55; y1 = 16'd61; color = 3'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    n_checks++;
    if (timed_out || obs_q.size() !== 8)
      $display("FAIL busy_start_count: got %0d timeout=%0d required 8", obs_q.size(), timed_out);
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL busy_start_pix[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    busy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || we !== 1'b0) busy_seen++;
    end
    n_checks++;
    if (busy_seen !== 0)
      $display("FAIL busy_start_no_second_line: got %0d active cycles required 0", busy_seen);
    else n_pass++;
  endtask

  task automatic test_start_in_done();
    int busy_seen;
    build_exp(0, 0, 7, 3, 6);
    start_line(0, 0, 7, 3, 6);
    fork
      capture();
      begin
        repeat (9) @(negedge clk);  // 8 DRAW cycles, then the DONE cycle
        x0 = 16'd20; y0 = 16'd20; x1 = 16'd30; y1 = 16'd30; color = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    n_checks++;
    if (timed_out || busy_at_done !== 1'b1 || obs_q.size() !== exp_q.size())
      $display("FAIL done_start_line: got count=%0d timeout=%0d busy_at_done=%b required %0d/0/1",
               obs_q.size(), timed_out, busy_at_done, exp_q.size());
    else n_pass++;
    busy_seen = 0;
    if (busy !== 1'b0) busy_seen++;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || we !== 1'b0 || done !== 1'b0) busy_seen++;
    end
    n_checks++;
    if (busy_seen !== 0)
      $display("FAIL done_start_ignored: got %0d active cycles required 0", busy_seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid_line();
    int stray;
    start_line(0, 0, 9, 0, 4);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({we, x, y} !== {1'b1, 16'd2, 16'd0})
      $display("FAIL midreset_third_pixel: got we=%b x=%0d y=%0d required 1,2,0", we, x, y);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, we, x, y} !== '0)
      $display("FAIL midreset_outputs: got busy=%b done=%b we=%b x=%0d y=%0d required all zero",
               busy, done, we, x, y);
    else n_pass++;
    rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || we !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_checks++;
    if (stray !== 0)
      $display("FAIL midreset_quiet: got %0d active cycles required 0", stray);
    else n_pass++;
    build_exp(1, 2, 4, 3, 3);
    start_line(1, 2, 4, 3, 3);
    capture();
    n_checks++;
    if (timed_out || obs_q.size() !== exp_q.size())
      $display("FAIL midreset_fresh_count: got %0d timeout=%0d required %0d", obs_q.size(), timed_out, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL midreset_fresh_pix[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_random_lines(input int n);
    int ax0, ay0, ax1, ay1, c, adx, ady, npix, bad;
    for (int t = 0; t < n; t++) begin
      ax0 = $urandom_range(0, 120); ay0 = $urandom_range(0, 120);
      ax1 = $urandom_range(0, 120); ay1 = $urandom_range(0, 120);
      c   = $urandom_range(0, 7);
      adx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      ady  = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
      npix = ((adx > ady) ? adx : ady) + 1;
      build_exp(ax0, ay0, ax1, ay1, c);
      start_line(ax0, ay0, ax1, ay1, c);
      capture();
      n_checks++;
      if (timed_out || obs_q.size() !== npix)
        $display("FAIL rand%0d_count (%0d,%0d)->(%0d,%0d): got %0d timeout=%0d required %0d",
                 t, ax0, ay0, ax1, ay1, obs_q.size(), timed_out, npix);
      else n_pass++;
      bad = -1;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      n_checks++;
      if (bad >= 0)
        $display("FAIL rand%0d_pix[%0d] (%0d,%0d)->(%0d,%0d): got %h required %h",
                 t, bad, ax0, ay0, ax1, ay1, obs_q[bad], exp_q[bad]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_horizontal();
    test_fixed_path("steep",    0,  0,   2,  5, 3);
    test_fixed_path("reversed", 10, 10,  7, 13, 6);
    test_fixed_path("single",   3,  3,   3,  3, 1);
    test_fixed_path("clip",     98, 50, 102, 50, 7);
    test_start_while_busy();
    test_start_in_done();
    test_reset_mid_line();
    test_random_lines(25);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
